// File: rtl/conveng_pkg.sv
// Shared definitions for the convolution engine blocks: default widths and
// the output-interface state type.
package conveng_pkg;

  localparam int XB_DEF    = 10;
  localparam int YB_DEF    = 10;
  localparam int PB_DEF    = 8;
  localparam int DEPTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } outinf_state_t;

endpackage

// File: rtl/outq.sv
// Small synchronous FIFO between the engine write side and the output register.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module outq #(
  parameter int PB    = 8,
  parameter int DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [PB-1:0] wr_data,
  output logic [PB-1:0] rd_data,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [PB-1:0] mem_q [DEPTH];
  logic          do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    if (do_pop)  rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/outinf.sv
// Output interface of the convolution engine: buffers engine pixels and emits
// them as a valid/ready stream tagged with sof/eol/eof for the configured frame.
module outinf
  import conveng_pkg::*;
#(
  parameter int XB    = XB_DEF,
  parameter int YB    = YB_DEF,
  parameter int PB    = PB_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [XB-1:0] cfg_width,
  input  logic [YB-1:0] cfg_height,
  input  logic [PB-1:0] eng_data,
  input  logic          eng_valid,
  output logic          eng_ready,
  output logic [PB-1:0] px_out_data,
  output logic          px_out_valid,
  input  logic          px_out_ready,
  output logic          px_out_sof,
  output logic          px_out_eol,
  output logic          px_out_eof,
  output logic [XB-1:0] col_count,
  output logic [YB-1:0] row_count,
  output logic          busy,
  output logic          frame_done
);

  // Handshake rule on both sides: a transfer happens on the rising edge where
  // valid and ready are both high; a held valid keeps its data stable until then.

  outinf_state_t state_q, state_d;
  logic [XB-1:0] cfg_w_q, cfg_w_d, wr_col_q, wr_col_d, col_q, col_d;
  logic [YB-1:0] cfg_h_q, cfg_h_d, wr_row_q, wr_row_d, row_q, row_d;
  logic          wr_done_q, wr_done_d;
  logic          out_valid_q, out_valid_d;
  logic [PB-1:0] out_data_q, out_data_d;

  logic          fifo_full, fifo_empty;
  logic [PB-1:0] fifo_data;
  logic          push, pop, hs;
  logic          col_last, row_last, wr_col_last, wr_row_last;

  assign col_last    = (col_q == cfg_w_q - XB'(1));
  assign row_last    = (row_q == cfg_h_q - YB'(1));
  assign wr_col_last = (wr_col_q == cfg_w_q - XB'(1));
  assign wr_row_last = (wr_row_q == cfg_h_q - YB'(1));

  assign eng_ready = (state_q == RUN) && !fifo_full && !wr_done_q;
  assign push      = eng_valid && eng_ready;
  assign pop       = !fifo_empty && (!out_valid_q || px_out_ready);
  assign hs        = out_valid_q && px_out_ready;

  outq #(
    .PB    (PB),
    .DEPTH (DEPTH)
  ) u_outq (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .pop     (pop),
    .wr_data (eng_data),
    .rd_data (fifo_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    cfg_w_d     = cfg_w_q;
    cfg_h_d     = cfg_h_q;
    wr_col_d    = wr_col_q;
    wr_row_d    = wr_row_q;
    wr_done_d   = wr_done_q;
    col_d       = col_q;
    row_d       = row_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    if (pop) begin
      out_valid_d = 1'b1;
      out_data_d  = fifo_data;
    end else if (hs) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (start && (cfg_width != '0) && (cfg_height != '0)) begin
          cfg_w_d   = cfg_width;
          cfg_h_d   = cfg_height;
          wr_col_d  = '0;
          wr_row_d  = '0;
          wr_done_d = 1'b0;
          col_d     = '0;
          row_d     = '0;
          state_d   = RUN;
        end
      end
      RUN: begin
        if (push) begin
          if (wr_col_last) begin
            wr_col_d = '0;
            if (wr_row_last) begin
              wr_row_d  = '0;
              wr_done_d = 1'b1;
            end else begin
              wr_row_d = wr_row_q + YB'(1);
            end
          end else begin
            wr_col_d = wr_col_q + XB'(1);
          end
        end
        // The last pixel of the frame closes it; write-side state is rearmed too.
        if (hs) begin
          if (col_last && row_last) begin
            col_d     = '0;
            row_d     = '0;
            wr_col_d  = '0;
            wr_row_d  = '0;
            wr_done_d = 1'b0;
            state_d   = DONE;
          end else if (col_last) begin
            col_d = '0;
            row_d = row_q + YB'(1);
          end else begin
            col_d = col_q + XB'(1);
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cfg_w_q     <= '0;
      cfg_h_q     <= '0;
      wr_col_q    <= '0;
      wr_row_q    <= '0;
      wr_done_q   <= 1'b0;
      col_q       <= '0;
      row_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cfg_w_q     <= cfg_w_d;
      cfg_h_q     <= cfg_h_d;
      wr_col_q    <= wr_col_d;
      wr_row_q    <= wr_row_d;
      wr_done_q   <= wr_done_d;
      col_q       <= col_d;
      row_q       <= row_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign px_out_data  = out_data_q;
  assign px_out_valid = out_valid_q;
  assign px_out_sof   = out_valid_q && (col_q == '0) && (row_q == '0);
  assign px_out_eol   = out_valid_q && col_last;
  assign px_out_eof   = out_valid_q && col_last && row_last;
  assign col_count    = col_q;
  assign row_count    = row_q;
  assign busy         = (state_q != IDLE);
  assign frame_done   = (state_q == DONE);

endmodule

// File: tb/tb_outinf.sv
// Directed bench for outinf: one task per scenario, inline checks, one summary line.
module tb_outinf;

  localparam int XB = 10;
  localparam int YB = 10;
  localparam int PB = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [XB-1:0] cfg_width;
  logic [YB-1:0] cfg_height;
  logic [PB-1:0] eng_data;
  logic          eng_valid;
  logic          eng_ready;
  logic [PB-1:0] px_out_data;
  logic          px_out_valid;
  logic          px_out_ready;
  logic          px_out_sof, px_out_eol, px_out_eof;
  logic [XB-1:0] col_count;
  logic [YB-1:0] row_count;
  logic          busy;
  logic          frame_done;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  outinf #(.XB(XB), .YB(YB), .PB(PB), .DEPTH(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .cfg_width    (cfg_width),
    .cfg_height   (cfg_height),
    .eng_data     (eng_data),
    .eng_valid    (eng_valid),
    .eng_ready    (eng_ready),
    .px_out_data  (px_out_data),
    .px_out_valid (px_out_valid),
    .px_out_ready (px_out_ready),
    .px_out_sof   (px_out_sof),
    .px_out_eol   (px_out_eol),
    .px_out_eof   (px_out_eof),
    .col_count    (col_count),
    .row_count    (row_count),
    .busy         (busy),
    .frame_done   (frame_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int w, input int h);
    start      = 1'b1;
    cfg_width  = XB'(w);
    cfg_height = YB'(h);
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; cfg_width = '0; cfg_height = '0;
    eng_data = '0; eng_valid = 1'b0; px_out_ready = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if ({eng_ready, px_out_valid, px_out_sof, px_out_eol, px_out_eof, busy, frame_done} !== 7'b0) begin
      n_bad++; $display("FAIL reset_flags got %b want 0000000",
        {eng_ready, px_out_valid, px_out_sof, px_out_eol, px_out_eof, busy, frame_done});
    end
    n_cmp++;
    if ({px_out_data, col_count, row_count} !== '0) begin
      n_bad++; $display("FAIL reset_data got %h/%0d/%0d want 0/0/0", px_out_data, col_count, row_count);
    end
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if ({busy, eng_ready, px_out_valid} !== 3'b000) begin
      n_bad++; $display("FAIL reset_release got %b want 000", {busy, eng_ready, px_out_valid});
    end
  endtask

  task automatic test_basic();
    int p;
    px_out_ready = 1'b1;
    do_start(4, 2);
    n_cmp++;
    if ({busy, eng_ready} !== 2'b11) begin
      n_bad++; $display("FAIL basic_run got busy/rdy %b want 11", {busy, eng_ready});
    end
    for (int t = 0; t < 10; t++) begin
      eng_valid = (t < 8);
      eng_data  = 8'(16 + t);
      if (t == 8) begin
        n_cmp++;
        if (eng_ready !== 1'b0) begin
          n_bad++; $display("FAIL basic_wr_done got eng_ready %b want 0", eng_ready);
        end
      end
      if (t < 2) begin
        n_cmp++;
        if (px_out_valid !== 1'b0) begin
          n_bad++; $display("FAIL basic_latency t=%0d got valid %b want 0", t, px_out_valid);
        end
      end else begin
        p = t - 2;
        n_cmp++;
        if (px_out_valid !== 1'b1 || px_out_data !== 8'(16 + p)) begin
          n_bad++; $display("FAIL basic_data p=%0d got %b/%h want 1/%h", p, px_out_valid, px_out_data, 8'(16 + p));
        end
        n_cmp++;
        if ({px_out_sof, px_out_eol, px_out_eof} !== {p == 0, (p % 4) == 3, p == 7}) begin
          n_bad++; $display("FAIL basic_flags p=%0d got %b want %b", p,
            {px_out_sof, px_out_eol, px_out_eof}, {p == 0, (p % 4) == 3, p == 7});
        end
        n_cmp++;
        if (col_count !== XB'(p % 4) || row_count !== YB'(p / 4)) begin
          n_bad++; $display("FAIL basic_pos p=%0d got %0d,%0d want %0d,%0d", p, col_count, row_count, p % 4, p / 4);
        end
      end
      tick();
    end
    n_cmp++;
    if ({frame_done, px_out_valid} !== 2'b10) begin
      n_bad++; $display("FAIL basic_frame_done got done/valid %b want 10", {frame_done, px_out_valid});
    end
    do_start(3, 1);
    n_cmp++;
    if ({frame_done, busy} !== 2'b00) begin
      n_bad++; $display("FAIL basic_start_in_done got done/busy %b want 00", {frame_done, busy});
    end
  endtask

  task automatic test_stall();
    int n, rcv;
    logic stall, done;
    logic [PB+XB+2:0] saved;
    px_out_ready = 1'b0;
    do_start(12, 1);
    n = 0;
    for (int c = 0; c < 12; c++) begin
      eng_valid = (n < 12);
      eng_data  = 8'(32 + n);
      if (eng_valid && eng_ready) n++;
      tick();
    end
    n_cmp++;
    if (n !== 9 || eng_ready !== 1'b0) begin
      n_bad++; $display("FAIL stall_fill got accepted %0d rdy %b want 9 0", n, eng_ready);
    end
    n_cmp++;
    if (px_out_valid !== 1'b1 || px_out_data !== 8'h20) begin
      n_bad++; $display("FAIL stall_head got %b/%h want 1/20", px_out_valid, px_out_data);
    end
    rcv = 0; stall = 1'b0; done = 1'b0; saved = '0;
    for (int c = 0; c < 200 && !done; c++) begin
      px_out_ready = c[0];
      eng_valid    = (n < 12);
      eng_data     = 8'(32 + n);
      if (px_out_valid && px_out_ready) begin
        n_cmp++;
        if (px_out_data !== 8'(32 + rcv) || col_count !== XB'(rcv)) begin
          n_bad++; $display("FAIL stall_seq k=%0d got %h col %0d want %h col %0d", rcv, px_out_data, col_count, 8'(32 + rcv), rcv);
        end
        n_cmp++;
        if ({px_out_sof, px_out_eol, px_out_eof} !== {rcv == 0, rcv == 11, rcv == 11}) begin
          n_bad++; $display("FAIL stall_flags k=%0d got %b want %b", rcv,
            {px_out_sof, px_out_eol, px_out_eof}, {rcv == 0, rcv == 11, rcv == 11});
        end
        rcv++;
      end else if (px_out_valid) begin
        saved = {px_out_data, px_out_sof, px_out_eol, px_out_eof, col_count};
        stall = 1'b1;
      end
      if (eng_valid && eng_ready) n++;
      tick();
      if (stall) begin
        n_cmp++;
        if ({px_out_valid, px_out_data, px_out_sof, px_out_eol, px_out_eof, col_count} !== {1'b1, saved}) begin
          n_bad++; $display("FAIL stall_hold got %h want %h",
            {px_out_valid, px_out_data, px_out_sof, px_out_eol, px_out_eof, col_count}, {1'b1, saved});
        end
        stall = 1'b0;
      end
      if (frame_done) done = 1'b1;
    end
    n_cmp++;
    if (rcv !== 12 || n !== 12 || done !== 1'b1) begin
      n_bad++; $display("FAIL stall_total got rcv %0d acc %0d done %b want 12 12 1", rcv, n, done);
    end
    tick();
  endtask

  task automatic test_overrun();
    int n, outs, bad_rdy;
    logic done;
    px_out_ready = 1'b1;
    do_start(2, 2);
    n = 0; outs = 0; bad_rdy = 0; done = 1'b0;
    for (int c = 0; c < 12; c++) begin
      eng_valid = 1'b1;
      eng_data  = 8'(48 + n);
      if (px_out_valid) outs++;
      if (eng_valid && eng_ready) n++;
      tick();
      if (n >= 4 && eng_ready) bad_rdy++;
      if (frame_done) done = 1'b1;
    end
    n_cmp++;
    if (n !== 4) begin
      n_bad++; $display("FAIL overrun_accepted got %0d want 4", n);
    end
    n_cmp++;
    if (bad_rdy !== 0 || eng_ready !== 1'b0) begin
      n_bad++; $display("FAIL overrun_ready got %0d cycles ready after 4th, now %b want 0 0", bad_rdy, eng_ready);
    end
    n_cmp++;
    if (outs !== 4 || done !== 1'b1) begin
      n_bad++; $display("FAIL overrun_out got %0d done %b want 4 1", outs, done);
    end
  endtask

  task automatic test_single();
    eng_valid    = 1'b0;
    px_out_ready = 1'b1;
    do_start(1, 1);
    n_cmp++;
    if (eng_ready !== 1'b1) begin
      n_bad++; $display("FAIL single_ready got %b want 1", eng_ready);
    end
    eng_valid = 1'b1;
    eng_data  = 8'hAA;
    tick();
    eng_valid = 1'b0;
    n_cmp++;
    if (px_out_valid !== 1'b0 || eng_ready !== 1'b0) begin
      n_bad++; $display("FAIL single_after_write got valid/rdy %b want 00", {px_out_valid, eng_ready});
    end
    tick();
    n_cmp++;
    if ({px_out_valid, px_out_data, px_out_sof, px_out_eol, px_out_eof} !== {1'b1, 8'hAA, 3'b111}) begin
      n_bad++; $display("FAIL single_pixel got %b/%h/%b want 1/aa/111",
        px_out_valid, px_out_data, {px_out_sof, px_out_eol, px_out_eof});
    end
    tick();
    n_cmp++;
    if (frame_done !== 1'b1) begin
      n_bad++; $display("FAIL single_done got %b want 1", frame_done);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int n, rcv;
    px_out_ready = 1'b1;
    do_start(4, 2);
    n = 0; rcv = 0;
    for (int c = 0; c < 20 && rcv < 3; c++) begin
      eng_valid = (n < 8);
      eng_data  = 8'(64 + n);
      if (px_out_valid && px_out_ready) rcv++;
      if (eng_valid && eng_ready) n++;
      tick();
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (rcv !== 3) begin
      n_bad++; $display("FAIL rstmid_progress got %0d want 3", rcv);
    end
    n_cmp++;
    if ({eng_ready, px_out_valid, px_out_sof, px_out_eol, px_out_eof, busy, frame_done} !== 7'b0 ||
        {px_out_data, col_count, row_count} !== '0) begin
      n_bad++; $display("FAIL rstmid_clear got flags %b data %h col %0d row %0d want all 0",
        {eng_ready, px_out_valid, px_out_sof, px_out_eol, px_out_eof, busy, frame_done},
        px_out_data, col_count, row_count);
    end
    eng_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    do_start(2, 1);
    eng_valid = 1'b1;
    eng_data  = 8'h51;
    tick();
    eng_data  = 8'h52;
    tick();
    eng_valid = 1'b0;
    n_cmp++;
    if ({px_out_valid, px_out_data, px_out_sof, px_out_eol, px_out_eof} !== {1'b1, 8'h51, 3'b100}) begin
      n_bad++; $display("FAIL rstmid_first got %b/%h/%b want 1/51/100",
        px_out_valid, px_out_data, {px_out_sof, px_out_eol, px_out_eof});
    end
    tick();
    n_cmp++;
    if ({px_out_valid, px_out_data, px_out_sof, px_out_eol, px_out_eof} !== {1'b1, 8'h52, 3'b011}) begin
      n_bad++; $display("FAIL rstmid_second got %b/%h/%b want 1/52/011",
        px_out_valid, px_out_data, {px_out_sof, px_out_eol, px_out_eof});
    end
    tick();
    n_cmp++;
    if (frame_done !== 1'b1) begin
      n_bad++; $display("FAIL rstmid_done got %b want 1", frame_done);
    end
    tick();
  endtask

  task automatic test_zero_dim();
    do_start(0, 5);
    n_cmp++;
    if ({busy, eng_ready} !== 2'b00) begin
      n_bad++; $display("FAIL zero_width got busy/rdy %b want 00", {busy, eng_ready});
    end
    tick();
    n_cmp++;
    if ({busy, eng_ready} !== 2'b00) begin
      n_bad++; $display("FAIL zero_width_hold got busy/rdy %b want 00", {busy, eng_ready});
    end
    do_start(3, 0);
    n_cmp++;
    if ({busy, eng_ready} !== 2'b00) begin
      n_bad++; $display("FAIL zero_height got busy/rdy %b want 00", {busy, eng_ready});
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_overrun();
    test_single();
    test_reset_mid();
    test_zero_dim();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached after %0d compared, want completion", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
